// File: rtl/writeback_regfile.sv
// Architectural register file written by the Writeback stage and read by Decode,
// with same-cycle write-through bypass, an a0 (x10) tap and a committed-write counter.
module writeback_regfile #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              RegWriteW,
    input  logic [ADDR_W-1:0] RdW,
    input  logic [WIDTH-1:0]  ResultW,
    input  logic [ADDR_W-1:0] A1,
    input  logic [ADDR_W-1:0] A2,
    output logic [WIDTH-1:0]  RD1,
    output logic [WIDTH-1:0]  RD2,
    output logic [WIDTH-1:0]  a0,
    output logic [CNT_W-1:0]  wb_count
);

    localparam int NREG = 1 << ADDR_W;

    // Entry 0 is cleared by reset and never written, so x0 stays hard-wired to 0.
    logic [WIDTH-1:0] regs [NREG];
    logic             commit;

    assign commit = RegWriteW && (RdW != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
            wb_count <= '0;
        end else if (commit) begin
            regs[RdW] <= ResultW;
            wb_count  <= wb_count + CNT_W'(1);
        end
    end

    // Bypass is suppressed during reset so reads stay 0 even with a write presented.
    always_comb begin
        RD1 = '0;
        if (!rst && (A1 != '0)) begin
            if (RegWriteW && (RdW == A1)) begin
                RD1 = ResultW;
            end else begin
                RD1 = regs[A1];
            end
        end
    end

    always_comb begin
        RD2 = '0;
        if (!rst && (A2 != '0)) begin
            if (RegWriteW && (RdW == A2)) begin
                RD2 = ResultW;
            end else begin
                RD2 = regs[A2];
            end
        end
    end

    assign a0 = regs[10];

endmodule

// File: tb/tb_writeback_regfile.sv
// Directed self-checking bench for writeback_regfile: reset, commit, bypass,
// x0 handling, disabled writes, a0 tap and counter wrap (CNT_W=4).
module tb_writeback_regfile;

    localparam int WIDTH  = 32;
    localparam int ADDR_W = 5;
    localparam int CNT_W  = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              RegWriteW;
    logic [ADDR_W-1:0] RdW;
    logic [WIDTH-1:0]  ResultW;
    logic [ADDR_W-1:0] A1;
    logic [ADDR_W-1:0] A2;
    logic [WIDTH-1:0]  RD1;
    logic [WIDTH-1:0]  RD2;
    logic [WIDTH-1:0]  a0;
    logic [CNT_W-1:0]  wb_count;

    int n_checks = 0;
    int n_fail   = 0;

    writeback_regfile #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .RegWriteW(RegWriteW), .RdW(RdW), .ResultW(ResultW),
        .A1(A1), .A2(A2), .RD1(RD1), .RD2(RD2), .a0(a0), .wb_count(wb_count)
    );

    always #5 clk = ~clk;

    task automatic write_cycle(input logic [ADDR_W-1:0] rd, input logic [WIDTH-1:0] val);
        @(negedge clk);
        RegWriteW = 1'b1; RdW = rd; ResultW = val;
        @(posedge clk); #1;
        RegWriteW = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; RegWriteW = 1'b1; RdW = 5'd5; ResultW = 32'h55; A1 = 5'd5; A2 = 5'd10;
        #1;
        n_checks++; if (RD1 !== 32'h0) begin n_fail++; $display("FAIL reset_rd1_bypass got %h exp %h", RD1, 32'h0); end
        n_checks++; if (a0 !== 32'h0) begin n_fail++; $display("FAIL reset_a0 got %h exp %h", a0, 32'h0); end
        n_checks++; if (wb_count !== 4'd0) begin n_fail++; $display("FAIL reset_count got %0d exp 0", wb_count); end
        @(posedge clk); #1;
        n_checks++; if (wb_count !== 4'd0) begin n_fail++; $display("FAIL reset_drop_count got %0d exp 0", wb_count); end
        @(negedge clk);
        rst = 1'b0; RegWriteW = 1'b0;
        #1;
        n_checks++; if (RD1 !== 32'h0) begin n_fail++; $display("FAIL reset_drop_reg5 got %h exp %h", RD1, 32'h0); end
        n_checks++; if (RD2 !== 32'h0) begin n_fail++; $display("FAIL reset_reg10 got %h exp %h", RD2, 32'h0); end
    endtask

    task automatic test_write_read();
        write_cycle(5'd5, 32'hDEADBEEF);
        A1 = 5'd5; A2 = 5'd5;
        #1;
        n_checks++; if (RD1 !== 32'hDEADBEEF) begin n_fail++; $display("FAIL wr_rd1 got %h exp %h", RD1, 32'hDEADBEEF); end
        n_checks++; if (RD2 !== 32'hDEADBEEF) begin n_fail++; $display("FAIL wr_rd2 got %h exp %h", RD2, 32'hDEADBEEF); end
        n_checks++; if (wb_count !== 4'd1) begin n_fail++; $display("FAIL wr_count got %0d exp 1", wb_count); end
    endtask

    task automatic test_bypass();
        @(negedge clk);
        RegWriteW = 1'b1; RdW = 5'd7; ResultW = 32'h1234; A1 = 5'd7; A2 = 5'd7;
        #1;
        n_checks++; if (RD1 !== 32'h1234) begin n_fail++; $display("FAIL byp_rd1 got %h exp %h", RD1, 32'h1234); end
        n_checks++; if (RD2 !== 32'h1234) begin n_fail++; $display("FAIL byp_rd2 got %h exp %h", RD2, 32'h1234); end
        @(posedge clk); #1;
        RegWriteW = 1'b0;
        #1;
        n_checks++; if (RD1 !== 32'h1234) begin n_fail++; $display("FAIL byp_stored got %h exp %h", RD1, 32'h1234); end
        n_checks++; if (wb_count !== 4'd2) begin n_fail++; $display("FAIL byp_count got %0d exp 2", wb_count); end
    endtask

    task automatic test_x0();
        @(negedge clk);
        RegWriteW = 1'b1; RdW = 5'd0; ResultW = 32'hFFFFFFFF; A1 = 5'd0; A2 = 5'd0;
        #1;
        n_checks++; if (RD1 !== 32'h0) begin n_fail++; $display("FAIL x0_before got %h exp %h", RD1, 32'h0); end
        n_checks++; if (RD2 !== 32'h0) begin n_fail++; $display("FAIL x0_before_rd2 got %h exp %h", RD2, 32'h0); end
        @(posedge clk); #1;
        RegWriteW = 1'b0;
        #1;
        n_checks++; if (RD1 !== 32'h0) begin n_fail++; $display("FAIL x0_after got %h exp %h", RD1, 32'h0); end
        n_checks++; if (wb_count !== 4'd2) begin n_fail++; $display("FAIL x0_count got %0d exp 2", wb_count); end
    endtask

    task automatic test_disabled();
        write_cycle(5'd3, 32'hAA);
        @(negedge clk);
        RegWriteW = 1'b0; RdW = 5'd3; ResultW = 32'd5; A1 = 5'd3;
        #1;
        n_checks++; if (RD1 !== 32'hAA) begin n_fail++; $display("FAIL dis_nobypass got %h exp %h", RD1, 32'hAA); end
        @(posedge clk); #1;
        n_checks++; if (RD1 !== 32'hAA) begin n_fail++; $display("FAIL dis_kept got %h exp %h", RD1, 32'hAA); end
        n_checks++; if (wb_count !== 4'd3) begin n_fail++; $display("FAIL dis_count got %0d exp 3", wb_count); end
        // Bypass must only hit the port whose address matches.
        @(negedge clk);
        RegWriteW = 1'b1; RdW = 5'd3; ResultW = 32'h77; A1 = 5'd5; A2 = 5'd3;
        #1;
        n_checks++; if (RD1 !== 32'hDEADBEEF) begin n_fail++; $display("FAIL part_rd1 got %h exp %h", RD1, 32'hDEADBEEF); end
        n_checks++; if (RD2 !== 32'h77) begin n_fail++; $display("FAIL part_rd2 got %h exp %h", RD2, 32'h77); end
        @(posedge clk); #1;
        RegWriteW = 1'b0;
        n_checks++; if (wb_count !== 4'd4) begin n_fail++; $display("FAIL part_count got %0d exp 4", wb_count); end
    endtask

    task automatic test_a0();
        @(negedge clk);
        RegWriteW = 1'b1; RdW = 5'd10; ResultW = 32'd42; A1 = 5'd10;
        #1;
        n_checks++; if (a0 !== 32'h0) begin n_fail++; $display("FAIL a0_nobypass got %h exp %h", a0, 32'h0); end
        n_checks++; if (RD1 !== 32'd42) begin n_fail++; $display("FAIL a0_rd1_bypass got %h exp %h", RD1, 32'd42); end
        @(posedge clk); #1;
        RegWriteW = 1'b0;
        n_checks++; if (a0 !== 32'd42) begin n_fail++; $display("FAIL a0_after got %h exp %h", a0, 32'd42); end
        n_checks++; if (wb_count !== 4'd5) begin n_fail++; $display("FAIL a0_count got %0d exp 5", wb_count); end
    endtask

    task automatic test_back_to_back_wrap();
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            RegWriteW = 1'b1; RdW = ADDR_W'(11 + i); ResultW = 32'(100 + i);
        end
        @(negedge clk);
        RegWriteW = 1'b0; A1 = 5'd11; A2 = 5'd21;
        #1;
        n_checks++; if (wb_count !== 4'd0) begin n_fail++; $display("FAIL wrap_count got %0d exp 0", wb_count); end
        n_checks++; if (RD1 !== 32'd100) begin n_fail++; $display("FAIL b2b_x11 got %h exp %h", RD1, 32'd100); end
        n_checks++; if (RD2 !== 32'd110) begin n_fail++; $display("FAIL b2b_x21 got %h exp %h", RD2, 32'd110); end
        write_cycle(5'd12, 32'h0BADF00D);
        A1 = 5'd12;
        #1;
        n_checks++; if (wb_count !== 4'd1) begin n_fail++; $display("FAIL post_wrap_count got %0d exp 1", wb_count); end
        n_checks++; if (RD1 !== 32'h0BADF00D) begin n_fail++; $display("FAIL overwrite_x12 got %h exp %h", RD1, 32'h0BADF00D); end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        A1 = 5'd5; A2 = 5'd3;
        #2;
        rst = 1'b1;
        #1;
        n_checks++; if (RD1 !== 32'h0) begin n_fail++; $display("FAIL arst_rd1 got %h exp %h", RD1, 32'h0); end
        n_checks++; if (RD2 !== 32'h0) begin n_fail++; $display("FAIL arst_rd2 got %h exp %h", RD2, 32'h0); end
        n_checks++; if (a0 !== 32'h0) begin n_fail++; $display("FAIL arst_a0 got %h exp %h", a0, 32'h0); end
        n_checks++; if (wb_count !== 4'd0) begin n_fail++; $display("FAIL arst_count got %0d exp 0", wb_count); end
        @(negedge clk);
        rst = 1'b0; RegWriteW = 1'b1; RdW = 5'd9; ResultW = 32'd99; A1 = 5'd9;
        @(posedge clk); #1;
        RegWriteW = 1'b0;
        #1;
        n_checks++; if (RD1 !== 32'd99) begin n_fail++; $display("FAIL resume_x9 got %h exp %h", RD1, 32'd99); end
        n_checks++; if (wb_count !== 4'd1) begin n_fail++; $display("FAIL resume_count got %0d exp 1", wb_count); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_bypass();
        test_x0();
        test_disabled();
        test_a0();
        test_back_to_back_wrap();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
